// File: rtl/zx_cartridge_bank_ctrl.sv
//------------------------------------------------------------------------------
// Module      : zx_cartridge_bank_ctrl
// Description : Z80 I/O-strobe driven 8 KB bank controller for the ZX cartridge
//               ROM, with glitch qualification, self-lock and ROM decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module zx_cartridge_bank_ctrl #(
  parameter int SELF_LOCK_VAL = 15,
  parameter int BANK_W        = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_PULSE     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_iorq_n,
  input  logic              i_rd_n,
  input  logic              i_mreq_n,
  input  logic              i_A7,
  input  logic              i_A13,
  input  logic              i_A14,
  input  logic              i_A15,
  output logic              o_ZX_ROM_blk,
  output logic              o_CR_ROM_oe_n,
  output logic [BANK_W-1:0] o_CR_ROM_A,
  output logic              o_self_lock,
  output logic              o_bank_strobe
);

  localparam int                CNT_W          = $clog2(MIN_PULSE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(MIN_PULSE - 1);
  localparam bit                LOCK_REACHABLE = (SELF_LOCK_VAL < (1 << BANK_W));
  localparam logic [BANK_W-1:0] LOCK_BANK      = BANK_W'(SELF_LOCK_VAL);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_QUAL     = 2'd1,
    S_COMMIT   = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_iorq_sync;
  logic [SYNC_STAGES-1:0] r_a7_sync;
  logic                   w_sel;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [BANK_W-1:0]      r_bank;
  logic                   r_self_lock;
  logic                   w_lower_rom;

  // Synchronisers reset to the inactive (high) level so reset never looks like a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iorq_sync <= '1;
      r_a7_sync   <= '1;
    end else begin
      r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], i_iorq_n};
      r_a7_sync   <= {r_a7_sync[SYNC_STAGES-2:0], i_A7};
    end
  end

  assign w_sel = ~r_iorq_sync[SYNC_STAGES-1] & ~r_a7_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!r_self_lock && w_sel) begin
          if (MIN_PULSE == 1) begin
            w_state_nxt = S_COMMIT;
          end else begin
            w_state_nxt = S_QUAL;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      S_QUAL: begin
        if (!w_sel) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_COMMIT: w_state_nxt = S_WAIT_REL;
      S_WAIT_REL: begin
        if (!w_sel) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lock is judged on the pre-increment bank, so the locking commit still advances it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank      <= '0;
      r_self_lock <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      r_bank <= r_bank + BANK_W'(1);
      if (LOCK_REACHABLE && (r_bank == LOCK_BANK)) r_self_lock <= 1'b1;
    end
  end

  assign w_lower_rom   = ~i_A15 & ~i_A14 & ~i_A13;
  assign o_CR_ROM_oe_n = ~w_lower_rom | i_rd_n | i_mreq_n | r_self_lock;
  assign o_ZX_ROM_blk  = ~o_CR_ROM_oe_n;
  assign o_CR_ROM_A    = r_bank;
  assign o_self_lock   = r_self_lock;
  assign o_bank_strobe = (r_state == S_COMMIT);

endmodule

`default_nettype wire
